// File: rtl/lifo_burst_reader.sv
// Read-side controller for the shift-register LIFO: pops words into
// framed valid/ready bursts and tracks stack occupancy from the push strobe.
module lifo_burst_reader #(
    parameter int DATA_W    = 8,
    parameter int LIFO_SIZE = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           lifo_data,
    input  logic                        lifo_val,
    input  logic                        lifo_full,
    input  logic                        lifo_wr,
    output logic                        lifo_read,
    input  logic                        flush,
    output logic [DATA_W-1:0]           m_data,
    output logic                        m_valid,
    output logic                        m_last,
    input  logic                        m_ready,
    output logic                        busy,
    output logic [$clog2(LIFO_SIZE):0]  occupancy,
    output logic [15:0]                 frames_sent,
    output logic                        sync_err
);

    localparam int OCC_W  = $clog2(LIFO_SIZE) + 1;
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;

    localparam logic [OCC_W-1:0]  OCC_BURST = OCC_W'(BURST_LEN);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(LIFO_SIZE);
    localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAIN     = 2'd1,
        LAST_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [OCC_W-1:0]    r_occ;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_flush_pend;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_m_valid;
    logic                r_m_last;
    logic [15:0]         r_frames;
    logic                r_sync_err;

    logic w_push;
    logic w_pop;
    logic w_slot_free;
    logic w_occ_zero;
    logic w_occ_full;
    logic w_is_last;
    logic w_trigger;
    logic w_sync_bad;

    assign w_occ_zero  = (r_occ == '0);
    assign w_occ_full  = (r_occ == OCC_FULL);
    assign w_slot_free = ~r_m_valid | m_ready;
    assign w_push      = lifo_wr & ~lifo_full;

    // The writer wins any collision, so the LIFO never sees read and write together.
    assign w_pop = ~reset & (r_state == DRAIN) & w_slot_free
                 & lifo_val & ~lifo_wr & ~w_occ_zero;

    assign w_is_last  = (r_beat == BEAT_LAST) | (r_occ == OCC_ONE);
    assign w_trigger  = ((r_occ >= OCC_BURST) | r_flush_pend) & ~w_occ_zero;
    assign w_sync_bad = (w_occ_zero != ~lifo_val) | (w_occ_full != lifo_full);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_occ        <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_frames     <= '0;
            r_sync_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_occ <= r_occ + OCC_ONE;
            end else if (w_pop) begin
                r_occ <= r_occ - OCC_ONE;
            end

            if (w_sync_bad) begin
                r_sync_err <= 1'b1;
            end

            if (flush) begin
                r_flush_pend <= 1'b1;
            end else if (r_state == IDLE && w_occ_zero) begin
                r_flush_pend <= 1'b0;
            end

            if (m_ready && !w_pop) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_state <= DRAIN;
                        r_beat  <= '0;
                    end
                end
                DRAIN: begin
                    if (w_pop) begin
                        r_m_data  <= lifo_data;
                        r_m_valid <= 1'b1;
                        r_m_last  <= w_is_last;
                        r_beat    <= r_beat + BEAT_ONE;
                        if (w_is_last) begin
                            r_state <= LAST_WAIT;
                        end
                    end
                end
                LAST_WAIT: begin
                    if (r_m_valid && m_ready) begin
                        r_frames <= r_frames + 16'd1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lifo_read   = w_pop;
    assign m_data      = r_m_data;
    assign m_valid     = r_m_valid;
    assign m_last      = r_m_last;
    assign busy        = (r_state != IDLE) | r_m_valid;
    assign occupancy   = r_occ;
    assign frames_sent = r_frames;
    assign sync_err    = r_sync_err;

endmodule
